lpc_host_seq: RTL and testbench

Transaction sequencer sitting directly upstream of the LPC host FSM. It accepts single-byte I/O or memory read/write requests on a valid/ready interface and drives the host's control pins: reset, frame request, read/write status and cycle type. It returns read data and a completion/error response, and recovers the host by pulsing its reset after a power-up or a hung cycle.

---
 rtl/lpc_host_seq_pkg.sv | 44 ++++
 rtl/lpc_seq_timer.sv | 25 ++
 rtl/lpc_host_seq.sv | 195 +++++++++++++++++++
 tb/tb_lpc_host_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_host_seq_pkg.sv
// Shared definitions for the LPC host transaction sequencer: state encoding,
// default hold/timeout lengths and the per-state host control pin decode.
package lpc_host_seq_pkg;

    localparam int unsigned LPC_RESET_CYCLES   = 4;
    localparam int unsigned LPC_TIMEOUT_CYCLES = 64;
    localparam int unsigned LPC_WAKE_CYCLES    = 2;

    typedef enum logic [2:0] {
        StReset = 3'd0,
        StWake  = 3'd1,
        StIdle  = 3'd2,
        StFrame = 3'd3,
        StCycle = 3'd4,
        StResp  = 3'd5
    } seq_state_e;

    typedef struct packed {
        logic nrst;
        logic lframe;
        logic rd_status;
        logic wr_status;
    } host_ctrl_t;

    localparam host_ctrl_t HOST_CTRL_RESET = '{nrst: 1'b0, lframe: 1'b1,
                                               rd_status: 1'b0, wr_status: 1'b0};

    // Host control pin levels for a given sequencer state.
    function automatic host_ctrl_t host_ctrl(seq_state_e st, logic write);
        host_ctrl_t c;
        c = '{nrst: 1'b1, lframe: 1'b1, rd_status: 1'b0, wr_status: 1'b0};
        case (st)
            StReset: c.nrst = 1'b0;
            StFrame: c.lframe = 1'b0;
            StCycle: begin
                c.rd_status = ~write;
                c.wr_status = write;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lpc_seq_timer.sv
// Loadable down-counter with a zero flag; shared by the reset hold, the wake
// hold and the cycle timeout of the sequencer.
module lpc_seq_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count_q;

    // Load wins; otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (load) begin
            count_q <= load_value;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/lpc_host_seq.sv
// LPC host transaction sequencer. Accepts one byte-wide I/O or memory request
// at a time, frames it to the host FSM, and returns read data / error.
// Optional feature macro: LPC_HOST_SEQ_TIMEOUT_EN enables the S_CYCLE timeout
// abort (error response followed by a host reset).
module lpc_host_seq
    import lpc_host_seq_pkg::*;
#(
    parameter int unsigned RESET_CYCLES   = LPC_RESET_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = LPC_TIMEOUT_CYCLES
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic        req_mem_i,
    input  logic [15:0] req_addr_i,
    input  logic [7:0]  req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [7:0]  rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [15:0] host_addr_o,
    output logic [7:0]  host_data_o,
    output logic        host_nrst_o,
    output logic        host_lframe_o,
    output logic        host_rd_status_o,
    output logic        host_wr_status_o,
    output logic        host_memory_cycle_o,
    input  logic [7:0]  host_data_i,
    input  logic        host_ready_i
);

    localparam int unsigned CNT_MAX = (RESET_CYCLES > TIMEOUT_CYCLES) ? RESET_CYCLES
                                                                      : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    // Timer loads are "length - 1" so that the state lasts exactly "length" cycles.
    localparam logic [CNT_W-1:0] RESET_LOAD = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LOAD  = CNT_W'(LPC_WAKE_CYCLES - 1);
`ifdef LPC_HOST_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    seq_state_e       state_q, state_d;
    host_ctrl_t       ctrl_q;
    logic             req_ready_q;
    logic             rsp_valid_q;
    logic [7:0]       rdata_q, rdata_d;
    logic [15:0]      addr_q;
    logic [7:0]       wdata_q;
    logic             write_q;
    logic             mem_q;
    logic             latch_req;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_value;
    logic             tmr_done;
    logic             resp_err;

`ifdef LPC_HOST_SEQ_TIMEOUT_EN
    logic err_q, err_d;
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    lpc_seq_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk        (clk_i),
        .load       (tmr_load),
        .load_value (tmr_value),
        .done       (tmr_done)
    );

    // Next-state, timer loads and response capture.
    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        tmr_value = '0;
        latch_req = 1'b0;
        rdata_d   = rdata_q;
`ifdef LPC_HOST_SEQ_TIMEOUT_EN
        err_d     = err_q;
`endif
        unique case (state_q)
            StReset: begin
                if (tmr_done) begin
                    state_d   = StWake;
                    tmr_load  = 1'b1;
                    tmr_value = WAKE_LOAD;
                end
            end
            StWake: begin
                if (tmr_done) state_d = StIdle;
            end
            StIdle: begin
                if (req_valid_i && req_ready_q) begin
                    state_d   = StFrame;
                    latch_req = 1'b1;
                end
            end
            StFrame: begin
                state_d = StCycle;
`ifdef LPC_HOST_SEQ_TIMEOUT_EN
                tmr_load  = 1'b1;
                tmr_value = TIMEOUT_LOAD;
`endif
            end
            StCycle: begin
                if (host_ready_i) begin
                    state_d = StResp;
                    rdata_d = write_q ? 8'h00 : host_data_i;
`ifdef LPC_HOST_SEQ_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (tmr_done) begin
                    state_d = StResp;
                    rdata_d = 8'h00;
                    err_d   = 1'b1;
`endif
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    if (resp_err) begin
                        state_d   = StReset;
                        tmr_load  = 1'b1;
                        tmr_value = RESET_LOAD;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StReset;
        endcase
        // Reset restarts the hold count from the beginning.
        if (rst_i) begin
            tmr_load  = 1'b1;
            tmr_value = RESET_LOAD;
        end
    end

    // State register and registered outputs decoded from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StReset;
            ctrl_q      <= HOST_CTRL_RESET;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 8'h00;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= host_ctrl(state_d, write_q);
            req_ready_q <= (state_d == StIdle);
            rsp_valid_q <= (state_d == StResp);
            rdata_q     <= rdata_d;
        end
    end

    // Request capture on handshake; these drive the host address/data/type pins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            write_q <= 1'b0;
            mem_q   <= 1'b0;
        end else if (latch_req) begin
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            write_q <= req_write_i;
            mem_q   <= req_mem_i;
        end
    end

`ifdef LPC_HOST_SEQ_TIMEOUT_EN
    // Error flag of the pending response.
    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end
`endif

    assign req_ready_o         = req_ready_q;
    assign rsp_valid_o         = rsp_valid_q;
    assign rsp_rdata_o         = rdata_q;
    assign rsp_err_o           = resp_err;
    assign host_addr_o         = addr_q;
    assign host_data_o         = wdata_q;
    assign host_memory_cycle_o = mem_q;
    assign host_nrst_o         = ctrl_q.nrst;
    assign host_lframe_o       = ctrl_q.lframe;
    assign host_rd_status_o    = ctrl_q.rd_status;
    assign host_wr_status_o    = ctrl_q.wr_status;

endmodule

// File: tb/tb_lpc_host_seq.sv
// Self-checking bench for lpc_host_seq: table of directed transactions plus
// hand-written reset, back-to-back, mid-cycle reset and hung-cycle sequences.
// The host FSM is stood in for by directly driving host_ready/host_data.
module tb_lpc_host_seq;

    localparam int unsigned RST_CYC = 4;
    localparam int unsigned TMO_CYC = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic        req_mem = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [15:0] host_addr;
    logic [7:0]  host_data_out;
    logic        host_nrst;
    logic        host_lframe;
    logic        host_rd_status;
    logic        host_wr_status;
    logic        host_mem;
    logic [7:0]  host_data_in = 8'hEE;
    logic        host_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lpc_host_seq #(
        .RESET_CYCLES   (RST_CYC),
        .TIMEOUT_CYCLES (TMO_CYC)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .req_valid_i         (req_valid),
        .req_ready_o         (req_ready),
        .req_write_i         (req_write),
        .req_mem_i           (req_mem),
        .req_addr_i          (req_addr),
        .req_wdata_i         (req_wdata),
        .rsp_valid_o         (rsp_valid),
        .rsp_ready_i         (rsp_ready),
        .rsp_rdata_o         (rsp_rdata),
        .rsp_err_o           (rsp_err),
        .host_addr_o         (host_addr),
        .host_data_o         (host_data_out),
        .host_nrst_o         (host_nrst),
        .host_lframe_o       (host_lframe),
        .host_rd_status_o    (host_rd_status),
        .host_wr_status_o    (host_wr_status),
        .host_memory_cycle_o (host_mem),
        .host_data_i         (host_data_in),
        .host_ready_i        (host_ready)
    );

    typedef struct {
        logic        write;
        logic        mem;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  pdata;      // byte the peripheral puts on the bus
        int unsigned waits;      // S_CYCLE cycles before host_ready
        int unsigned stall;      // cycles rsp_ready is held low
        logic [7:0]  exp_rdata;
        logic        exp_rd;
        logic        exp_wr;
        logic        exp_mem;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        int nlow;
        int first_ready;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 8'h00);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_nrst", host_nrst, 0);
        check("rst_lframe", host_lframe, 1);
        check("rst_status", {host_rd_status, host_wr_status}, 2'b00);
        check("rst_addr_data_mem", {host_addr, host_data_out, host_mem}, 25'h0);
        rst = 1'b0;
        nlow = 1;
        first_ready = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (!host_nrst) nlow++;
            if (req_ready && first_ready == 0) first_ready = k;
        end
        check("rst_nrst_low_cycles", nlow, RST_CYC);
        check("rst_first_ready_cycle", first_ready, RST_CYC + 2);
    endtask

    // Present a request, wait (bounded) for acceptance, check the frame cycle.
    task automatic accept_req(input vec_t v);
        int   n;
        logic acc;
        logic pre;
        req_write = v.write;
        req_mem   = v.mem;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_valid = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 40) begin
            pre = req_ready;
            tick();
            n++;
            if (pre) acc = 1'b1;
        end
        req_valid = 1'b0;
        check("accept", acc, 1);
        check("frame_lframe_low", host_lframe, 0);
        check("frame_status", {host_rd_status, host_wr_status}, 2'b00);
        check("frame_addr", host_addr, v.addr);
        check("frame_mem", host_mem, v.exp_mem);
        if (v.write) check("frame_wdata", host_data_out, v.wdata);
    endtask

    // S_CYCLE: statuses held while waiting, then the host completes.
    task automatic cycle_phase(input vec_t v);
        int bad;
        tick();
        check("cycle_lframe_high", host_lframe, 1);
        bad = 0;
        for (int i = 0; i < int'(v.waits); i++) begin
            if (host_rd_status !== v.exp_rd || host_wr_status !== v.exp_wr) bad++;
            if (rsp_valid !== 1'b0 || host_lframe !== 1'b1) bad++;
            tick();
        end
        check("cycle_status_held", bad, 0);
        check("cycle_status_last", {host_rd_status, host_wr_status}, {v.exp_rd, v.exp_wr});
        host_ready   = 1'b1;
        host_data_in = v.pdata;
        tick();
        host_ready   = 1'b0;
        host_data_in = 8'hEE;
        check("resp_valid", rsp_valid, 1);
        check("resp_rdata", rsp_rdata, v.exp_rdata);
        check("resp_err", rsp_err, 0);
        check("resp_status_dropped", {host_rd_status, host_wr_status}, 2'b00);
    endtask

    task automatic rsp_phase(input int unsigned stall, input logic [7:0] exp_rdata);
        int bad;
        bad = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < int'(stall); i++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_err !== 1'b0) bad++;
        end
        check("rsp_stall_stable", bad, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_done_valid_low", rsp_valid, 0);
        check("rsp_done_idle_ready", req_ready, 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   bad;
        int   cnt;
        vec_t b;

        //          wr    mem   addr      wdata  pdata  waits stall exp    rd    wr    mem
        vecs[0] = '{1'b0, 1'b0, 16'h004C, 8'h00, 8'hA5, 11, 0, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 16'hFED4, 8'h3C, 8'hFF, 12, 0, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 16'h1234, 8'h99, 8'h5A, 3,  2, 8'h5A, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 16'h0080, 8'hC3, 8'h77, 1,  1, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 16'hFFFF, 8'h00, 8'h81, 1,  0, 8'h81, 1'b1, 1'b0, 1'b0};

        tick();
        do_reset();

        for (int i = 0; i < 5; i++) begin
            accept_req(vecs[i]);
            cycle_phase(vecs[i]);
            rsp_phase(vecs[i].stall, vecs[i].exp_rdata);
        end

        // Back-to-back reads with the response held off for 5 cycles.
        accept_req(vecs[0]);
        cycle_phase(vecs[0]);
        b = vecs[2];
        req_write = b.write;
        req_mem   = b.mem;
        req_addr  = b.addr;
        req_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hA5) bad++;
            if (req_ready !== 1'b0 || host_lframe !== 1'b1) bad++;
        end
        check("b2b_hold_stable", bad, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("b2b_no_frame_in_idle", host_lframe, 1);
        check("b2b_rsp_released", rsp_valid, 0);
        accept_req(b);
        cycle_phase(b);
        rsp_phase(0, b.exp_rdata);

        // Reset asserted while the host is in its address phase.
        accept_req(vecs[1]);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_nrst_low", host_nrst, 0);
        check("midrst_no_rsp", rsp_valid, 0);
        check("midrst_status", {host_lframe, host_rd_status, host_wr_status}, 3'b100);
        check("midrst_addr_cleared", host_addr, 16'h0000);
        bad = 0;
        cnt = 0;
        while (!req_ready && cnt < 30) begin
            tick();
            cnt++;
            if (rsp_valid) bad++;
        end
        check("midrst_rsp_suppressed", bad, 0);
        check("midrst_ready_cycle", cnt, RST_CYC + 2);
        accept_req(vecs[4]);
        cycle_phase(vecs[4]);
        rsp_phase(0, vecs[4].exp_rdata);

`ifdef LPC_HOST_SEQ_TIMEOUT_EN
        // Peripheral never finishes sync: timeout, error response, host reset.
        accept_req(vecs[0]);
        tick();
        bad = 0;
        cnt = 0;
        while (!rsp_valid && cnt < 200) begin
            if (!host_rd_status) bad++;
            cnt++;
            tick();
        end
        check("tmo_status_held", bad, 0);
        check("tmo_cycles", cnt, TMO_CYC);
        check("tmo_err", rsp_err, 1);
        check("tmo_rdata", rsp_rdata, 8'h00);
        check("tmo_status_dropped", {host_rd_status, host_wr_status}, 2'b00);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        cnt = 0;
        while (!host_nrst && cnt < 50) begin
            cnt++;
            tick();
        end
        check("tmo_nrst_low_cycles", cnt, RST_CYC);
        tick();
        tick();
        check("tmo_ready_again", req_ready, 1);
        accept_req(vecs[2]);
        cycle_phase(vecs[2]);
        rsp_phase(0, vecs[2].exp_rdata);
`else
        // Without the timeout a hung cycle simply waits; recover with rst.
        accept_req(vecs[0]);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || host_rd_status !== 1'b1) bad++;
        end
        check("hang_waits_forever", bad, 0);
        do_reset();
        accept_req(vecs[3]);
        cycle_phase(vecs[3]);
        rsp_phase(0, vecs[3].exp_rdata);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
